tanh_5_slices: RTL and testbench



---
 rtl/tanh_5_slices.sv | 185 ++++++++++++++++++
 tb/tb_tanh_5_slices.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tanh_5_slices.sv
// Dual-lane, 3-stage pipelined tanh approximator on Q5.11 data using a 5-slice
// piecewise-linear fit on |x|. Define TANH5_ROUND_EN to round the product instead of truncating.
module tanh_5_slices (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x0_in,
  input  logic [15:0] x1_in,
  input  logic        valid_in,
  output logic [15:0] y0_out,
  output logic [15:0] y1_out,
  output logic        valid_out
);

  typedef enum logic [2:0] {
    SliceS0,
    SliceS1,
    SliceS2,
    SliceS3,
    SliceSat
  } slice_e;

  localparam logic [14:0] Brk1 = 15'd1024;
  localparam logic [14:0] Brk2 = 15'd2048;
  localparam logic [14:0] Brk3 = 15'd3072;
  localparam logic [14:0] Brk4 = 15'd5120;

`ifdef TANH5_ROUND_EN
  localparam logic [27:0] RoundBias = 28'd1024;
`else
  localparam logic [27:0] RoundBias = 28'd0;
`endif

  // Valid shift register: bit i qualifies the data held in stage i+1.
  logic [2:0] valid_q;

  logic [15:0] x_in [2];
  assign x_in[0] = x0_in;
  assign x_in[1] = x1_in;

  // Stage 1: magnitude, sign and slice index
  logic [14:0] abs_d   [2];
  slice_e      slice_d [2];
  logic [14:0] abs_q   [2];
  slice_e      slice_q [2];
  logic        neg1_q  [2];

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      abs_d[l]   = x_in[l][14:0];
      slice_d[l] = SliceS0;
      // -32768 has no positive counterpart; clamp it to the largest magnitude.
      if (x_in[l] == 16'h8000) begin
        abs_d[l] = 15'h7fff;
      end else if (x_in[l][15]) begin
        abs_d[l] = 15'(-x_in[l]);
      end
      if (abs_d[l] < Brk1) begin
        slice_d[l] = SliceS0;
      end else if (abs_d[l] < Brk2) begin
        slice_d[l] = SliceS1;
      end else if (abs_d[l] < Brk3) begin
        slice_d[l] = SliceS2;
      end else if (abs_d[l] < Brk4) begin
        slice_d[l] = SliceS3;
      end else begin
        slice_d[l] = SliceSat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        abs_q[l]   <= '0;
        slice_q[l] <= SliceS0;
        neg1_q[l]  <= 1'b0;
      end
    end else if (valid_in) begin
      for (int l = 0; l < 2; l++) begin
        abs_q[l]   <= abs_d[l];
        slice_q[l] <= slice_d[l];
        neg1_q[l]  <= x_in[l][15];
      end
    end
  end

  // Stage 2: coefficient lookup and scaled product
  logic [10:0] m_sel   [2];
  logic [10:0] c_sel   [2];
  logic [27:0] prod    [2];
  logic [27:0] prod_sh [2];
  logic [11:0] sh_q    [2];
  logic [10:0] c_q     [2];
  logic        neg2_q  [2];

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      m_sel[l] = 11'd0;
      c_sel[l] = 11'd0;
      unique case (slice_q[l])
        SliceS0: begin
          m_sel[l] = 11'd1893;
          c_sel[l] = 11'd0;
        end
        SliceS1: begin
          m_sel[l] = 11'd1227;
          c_sel[l] = 11'd333;
        end
        SliceS2: begin
          m_sel[l] = 11'd588;
          c_sel[l] = 11'd972;
        end
        SliceS3: begin
          m_sel[l] = 11'd167;
          c_sel[l] = 11'd1603;
        end
        // Saturated slice: zero slope, offset is the full-scale magnitude.
        SliceSat: begin
          m_sel[l] = 11'd0;
          c_sel[l] = 11'd2047;
        end
        default: begin
          m_sel[l] = 11'd0;
          c_sel[l] = 11'd0;
        end
      endcase
      prod[l]    = 28'(m_sel[l]) * 28'(abs_q[l]) + ((m_sel[l] != 11'd0) ? RoundBias : 28'd0);
      prod_sh[l] = prod[l] >> 11;
    end
  end

  // Shifted product never exceeds 12 bits for the slope/range pairs in use.
  logic unused_prod_hi;
  assign unused_prod_hi = ^{prod_sh[0][27:12], prod_sh[1][27:12]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        sh_q[l]   <= '0;
        c_q[l]    <= '0;
        neg2_q[l] <= 1'b0;
      end
    end else if (valid_q[0]) begin
      for (int l = 0; l < 2; l++) begin
        sh_q[l]   <= prod_sh[l][11:0];
        c_q[l]    <= c_sel[l];
        neg2_q[l] <= neg1_q[l];
      end
    end
  end

  // Stage 3: offset add and sign restore
  logic [11:0] sum [2];
  logic [15:0] mag [2];
  logic [15:0] y_d [2];

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      sum[l] = sh_q[l] + {1'b0, c_q[l]};
      mag[l] = {4'b0000, sum[l]};
      y_d[l] = neg2_q[l] ? 16'(-mag[l]) : mag[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_out <= '0;
      y1_out <= '0;
    end else if (valid_q[1]) begin
      y0_out <= y_d[0];
      y1_out <= y_d[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[1:0], valid_in};
    end
  end

  assign valid_out = valid_q[2];

endmodule

// File: tb/tb_tanh_5_slices.sv
// Directed self-checking bench for tanh_5_slices: reset, latency, slice coverage,
// extremes, streaming accuracy/symmetry and output hold.
module tb_tanh_5_slices;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] x0_in = '0;
  logic [15:0] x1_in = '0;
  logic        valid_in = 1'b0;
  logic [15:0] y0_out;
  logic [15:0] y1_out;
  logic        valid_out;

  int n_checks = 0;
  int n_errors = 0;

  int xs [20];
  int ys [20];

  always #5 clk = ~clk;

  tanh_5_slices dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x0_in     (x0_in),
    .x1_in     (x1_in),
    .valid_in  (valid_in),
    .y0_out    (y0_out),
    .y1_out    (y1_out),
    .valid_out (valid_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle valid pulse; result is checked after the third edge following capture.
  task automatic run_pair(input string tag, input int x0, input int x1, input int e0,
                          input int e1);
    @(posedge clk); #1;
    x0_in    = 16'(x0);
    x1_in    = 16'(x1);
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_valid"}, int'(valid_out), 1);
    check({tag, "_y0"}, int'($signed(y0_out)), e0);
    check({tag, "_y1"}, int'($signed(y1_out)), e1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    real r;
    real err;
    int  e;

    // Reset held with valid_in high: nothing may leak out.
    x0_in    = 16'd1024;
    x1_in    = 16'(-1024);
    valid_in = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_valid", int'(valid_out), 0);
      check("rst_y0", int'($signed(y0_out)), 0);
      check("rst_y1", int'($signed(y1_out)), 0);
    end
    valid_in = 1'b0;
    #2 rst_n = 1'b1;

    // Latency: presented before E0, captured at E1, visible only after E3.
    @(posedge clk); #1;
    x0_in    = 16'd0;
    x1_in    = 16'd1024;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("lat_e1_valid", int'(valid_out), 0);
    @(posedge clk); #1;
    check("lat_e2_valid", int'(valid_out), 0);
    @(posedge clk); #1;
    check("lat_e3_valid", int'(valid_out), 1);
    check("lat_y0", int'($signed(y0_out)), 0);
`ifdef TANH5_ROUND_EN
    check("lat_y1", int'($signed(y1_out)), 947);
`else
    check("lat_y1", int'($signed(y1_out)), 946);
`endif
    @(posedge clk); #1;
    check("lat_e4_valid", int'(valid_out), 0);

    // Slice coverage and extremes
`ifdef TANH5_ROUND_EN
    run_pair("s2_s3", 2048, 3072, 1560, 1854);
`else
    run_pair("s2_s3", 2048, 3072, 1560, 1853);
`endif
    run_pair("s0_s4", -538, 5120, -497, 2047);
    run_pair("neg_sat", -10240, 1, -2047, 0);
    run_pair("extreme", 32767, -32768, 2047, -2047);

    // Mid-stream asynchronous reset discards everything in flight.
    @(posedge clk); #1;
    x0_in    = 16'd2048;
    x1_in    = 16'(-2048);
    valid_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_pre_valid", int'(valid_out), 1);
    check("mid_pre_y1", int'($signed(y1_out)), -1560);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(valid_out), 0);
    check("mid_rst_y0", int'($signed(y0_out)), 0);
    check("mid_rst_y1", int'($signed(y1_out)), 0);
    valid_in = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("mid_flush_valid", int'(valid_out), 0);
      check("mid_flush_y0", int'($signed(y0_out)), 0);
    end

    // Streaming: 20 linspace points over [-5, 5], truncated toward zero.
    for (int k = 0; k < 20; k++) begin
      xs[k] = (-194560 + 20480 * k) / 19;
      ys[k] = 0;
    end
    for (int t = 0; t < 13; t++) begin
      if (t < 10) begin
        x0_in    = 16'(xs[2 * t]);
        x1_in    = 16'(xs[2 * t + 1]);
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      @(posedge clk); #1;
      if (t < 2) begin
        check("stream_lead_valid", int'(valid_out), 0);
      end else if (t < 12) begin
        check("stream_valid", int'(valid_out), 1);
        ys[2 * (t - 2)]     = int'($signed(y0_out));
        ys[2 * (t - 2) + 1] = int'($signed(y1_out));
      end else begin
        // Hold: valid drops, outputs keep the last pair (both in the saturated slice).
        check("hold_valid", int'(valid_out), 0);
        check("hold_y0", int'($signed(y0_out)), 2047);
        check("hold_y1", int'($signed(y1_out)), 2047);
      end
    end
    @(posedge clk); #1;
    check("hold2_valid", int'(valid_out), 0);
    check("hold2_y1", int'($signed(y1_out)), 2047);

    // Chord error of the 0.5..1.0 slice peaks near 47 LSB, hence a 48 LSB bound.
    for (int k = 0; k < 20; k++) begin
      r   = $tanh(real'(xs[k]) / 2048.0) * 2048.0;
      err = real'(ys[k]) - r;
      if (err < 0.0) err = -err;
      e = (err <= 48.0) ? 0 : int'(err);
      check("stream_tol", e, 0);
    end
    for (int k = 0; k < 10; k++) begin
      check("stream_odd", ys[k], -ys[19 - k]);
    end
    check("stream_mid_pos", ys[10], 497);
    check("stream_mid_neg", ys[9], -497);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
